// File: rtl/vend_pkg.sv
// Shared types and constants for the vending sequencer.
package vend_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    VEND    = 2'd2,
    CHANGE  = 2'd3
  } state_e;

  localparam int unsigned COIN5_VAL   = 5;
  localparam int unsigned COIN10_VAL  = 10;
  localparam int unsigned CHANGE_UNIT = 5;

endpackage

// File: rtl/vend_edge_det.sv
// Registered rising-edge detector: a level held for many cycles yields one pulse.
module vend_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic sig,
  output logic rise_c
);

  logic prev_q;

  // Remember last cycle's level.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) prev_q <= 1'b0;
    else      prev_q <= sig;
  end

  assign rise_c = sig & ~prev_q;

endmodule

// File: rtl/vend_sequencer.sv
// Vending machine controller: coin credit, dispense handshake, 5-unit change/refund payout.
// Optional auto-refund timeout in COLLECT is built when VEND_TIMEOUT_EN is defined.
module vend_sequencer
  import vend_pkg::*;
#(
  parameter int unsigned PRICE       = 20,
  parameter int unsigned MAX_CREDIT  = 40,
  parameter int unsigned CREDIT_W    = 6,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                coin5,
  input  logic                coin10,
  input  logic                cancel,
  input  logic                vend_done,
  input  logic                change_ack,
  output logic                dispense,
  output logic                change_req,
  output logic                coin_reject,
  output logic                busy,
  output logic [CREDIT_W-1:0] credit
);

  localparam int unsigned SUM_W = CREDIT_W + 1;

  state_e              state_q, next_state;
  logic [CREDIT_W-1:0] credit_d;
  logic                dispense_d, change_req_d, coin_reject_d, busy_d;

  logic                coin5_rise_c, coin10_rise_c, cancel_rise_c;
  logic [SUM_W-1:0]    coin_sum_c;
  logic                coin_edge_c, coin_ok_c, accept_c, timeout_c;

  vend_edge_det u_coin5_ed  (.clk(clk), .rst(rst), .sig(coin5),  .rise_c(coin5_rise_c));
  vend_edge_det u_coin10_ed (.clk(clk), .rst(rst), .sig(coin10), .rise_c(coin10_rise_c));
  vend_edge_det u_cancel_ed (.clk(clk), .rst(rst), .sig(cancel), .rise_c(cancel_rise_c));

  // Candidate credit for the incoming coin, one bit wider so the ceiling check cannot wrap.
  always_comb begin
    coin_edge_c = coin5_rise_c | coin10_rise_c;
    coin_sum_c  = {1'b0, credit} + (coin5_rise_c ? SUM_W'(COIN5_VAL) : SUM_W'(COIN10_VAL));
    coin_ok_c   = (coin5_rise_c ^ coin10_rise_c) && (coin_sum_c <= SUM_W'(MAX_CREDIT));
  end

`ifdef VEND_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC + 1);

  logic [TMO_W-1:0] tmo_q;

  // Idle-cycle counter in COLLECT; restarts on every accepted coin.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                 tmo_q <= '0;
    else if (next_state != COLLECT || accept_c) tmo_q <= '0;
    else                                      tmo_q <= tmo_q + TMO_W'(1);
  end

  assign timeout_c = (state_q == COLLECT) && (tmo_q == TMO_W'(TIMEOUT_CYC - 1));
`else
  logic unused_tmo;

  assign timeout_c  = 1'b0;
  assign unused_tmo = ^TIMEOUT_CYC;
`endif

  // Next state, next credit and next registered outputs.
  always_comb begin
    next_state = state_q;
    credit_d   = credit;
    accept_c   = 1'b0;

    case (state_q)
      IDLE: begin
        if (coin_ok_c) begin
          accept_c   = 1'b1;
          credit_d   = CREDIT_W'(coin_sum_c);
          next_state = (coin_sum_c >= SUM_W'(PRICE)) ? VEND : COLLECT;
        end
      end
      COLLECT: begin
        if (cancel_rise_c) begin
          next_state = (credit == '0) ? IDLE : CHANGE;
        end else if (coin_ok_c) begin
          accept_c   = 1'b1;
          credit_d   = CREDIT_W'(coin_sum_c);
          next_state = (coin_sum_c >= SUM_W'(PRICE)) ? VEND : COLLECT;
        end else if (timeout_c) begin
          next_state = (credit == '0) ? IDLE : CHANGE;
        end
      end
      VEND: begin
        // vend_done only counts as the answer to an asserted dispense.
        if (dispense && vend_done) begin
          credit_d   = credit - CREDIT_W'(PRICE);
          next_state = (credit == CREDIT_W'(PRICE)) ? IDLE : CHANGE;
        end
      end
      CHANGE: begin
        if (credit == '0) begin
          next_state = IDLE;
        end else if (change_req && change_ack) begin
          credit_d   = credit - CREDIT_W'(CHANGE_UNIT);
          next_state = (credit == CREDIT_W'(CHANGE_UNIT)) ? IDLE : CHANGE;
        end
      end
      default: next_state = IDLE;
    endcase

    coin_reject_d = coin_edge_c & ~accept_c;
    dispense_d    = (state_q == VEND) && (next_state == VEND);
    change_req_d  = (next_state == CHANGE) && (credit_d != '0);
    busy_d        = (next_state == VEND) || (next_state == CHANGE);
  end

  // State, credit and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      credit      <= '0;
      dispense    <= 1'b0;
      change_req  <= 1'b0;
      coin_reject <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state_q     <= next_state;
      credit      <= credit_d;
      dispense    <= dispense_d;
      change_req  <= change_req_d;
      coin_reject <= coin_reject_d;
      busy        <= busy_d;
    end
  end

endmodule

// File: tb/tb_vend_sequencer.sv
// Scoreboard bench for vend_sequencer: expected output events are queued, a negedge monitor matches them.
module tb_vend_sequencer;

  localparam int K_CREDIT = 0;
  localparam int K_REJ    = 1;
  localparam int K_DISP   = 2;
  localparam int K_REQ    = 3;
  localparam int K_BUSY   = 4;
  localparam int TMO      = 255;

  typedef struct {
    int kind;
    int val;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       coin5 = 1'b0, coin10 = 1'b0, cancel = 1'b0;
  logic       vend_done = 1'b0, change_ack = 1'b0;
  logic       dispense, change_req, coin_reject, busy;
  logic [5:0] credit;

  logic       hop_en = 1'b1;
  ev_t        exp_q[$];
  int         cmp_count = 0;
  int         err_count = 0;

  logic [5:0] p_credit = '0;
  logic       p_disp = 1'b0, p_req = 1'b0, p_busy = 1'b0;

  vend_sequencer dut (
    .clk(clk), .rst(rst), .coin5(coin5), .coin10(coin10), .cancel(cancel),
    .vend_done(vend_done), .change_ack(change_ack), .dispense(dispense),
    .change_req(change_req), .coin_reject(coin_reject), .busy(busy), .credit(credit)
  );

  always #5 clk = ~clk;

  function automatic string kname(input int k);
    case (k)
      K_CREDIT: return "credit";
      K_REJ:    return "coin_reject";
      K_DISP:   return "dispense";
      K_REQ:    return "change_req";
      default:  return "busy";
    endcase
  endfunction

  task automatic exp_ev(input int k, input int v);
    ev_t e;
    e.kind = k;
    e.val  = v;
    exp_q.push_back(e);
  endtask

  task automatic observe(input int k, input int v);
    ev_t e;
    cmp_count++;
    if (exp_q.size() == 0) begin
      err_count++;
      $display("FAIL unexpected_event: got %s=%0d, required no event (t=%0t)", kname(k), v, $time);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != k || e.val != v) begin
        err_count++;
        $display("FAIL event_order: got %s=%0d, required %s=%0d (t=%0t)",
                 kname(k), v, kname(e.kind), e.val, $time);
      end
    end
  endtask

  task automatic chk(input string name, input int act, input int req);
    cmp_count++;
    if (act != req) begin
      err_count++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input int which);
    case (which)
      0: coin5  = 1'b1;
      1: coin10 = 1'b1;
      default: cancel = 1'b1;
    endcase
    tick();
    coin5  = 1'b0;
    coin10 = 1'b0;
    cancel = 1'b0;
    tick();
  endtask

  // which: 0 = dispense, 1 = change_req
  task automatic wait_sig(input int which, input logic lvl, input int budget, input string name);
    logic found;
    found = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (((which == 0) ? dispense : change_req) == lvl) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    if (!found) begin
      cmp_count++;
      err_count++;
      $display("FAIL %s: got timeout after %0d cycles, required level %0b", name, budget, lvl);
    end
  endtask

  task automatic wait_drain(input int budget, input string name);
    for (int i = 0; i < budget; i++) begin
      if (exp_q.size() == 0) break;
      tick();
    end
    if (exp_q.size() != 0) begin
      cmp_count++;
      err_count++;
      $display("FAIL %s: got %0d events still pending (next %s=%0d), required 0",
               name, exp_q.size(), kname(exp_q[0].kind), exp_q[0].val);
      exp_q.delete();
    end
    repeat (4) tick();
  endtask

  // Output monitor: every change of a watched output is one event.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        if (credit != p_credit) observe(K_CREDIT, int'(credit));
        if (coin_reject)        observe(K_REJ, 1);
        if (dispense != p_disp) observe(K_DISP, int'(dispense));
        if (change_req != p_req) observe(K_REQ, int'(change_req));
        if (busy != p_busy)     observe(K_BUSY, int'(busy));
      end
      p_credit = credit;
      p_disp   = dispense;
      p_req    = change_req;
      p_busy   = busy;
    end
  end

  // Hopper model: answers each request cycle with a one-cycle ack.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (hop_en && change_req && !change_ack) change_ack = 1'b1;
      else                                     change_ack = 1'b0;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got simulation still running, required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_credit", int'(credit), 0);
    chk("rst_dispense", int'(dispense), 0);
    chk("rst_change_req", int'(change_req), 0);
    chk("rst_coin_reject", int'(coin_reject), 0);
    chk("rst_busy", int'(busy), 0);
    rst = 1'b1;
    tick();

    // 5+5+10 exact price, no change
    exp_ev(K_CREDIT, 5);
    exp_ev(K_CREDIT, 10);
    exp_ev(K_CREDIT, 20); exp_ev(K_BUSY, 1);
    exp_ev(K_DISP, 1);
    exp_ev(K_CREDIT, 0); exp_ev(K_DISP, 0); exp_ev(K_BUSY, 0);
    pulse(0); pulse(0); pulse(1);
    wait_sig(0, 1'b1, 20, "t1_dispense_rise");
    repeat (3) tick();
    vend_done = 1'b1;
    tick();
    vend_done = 1'b0;
    wait_drain(40, "t1_drain");

    // 5+10+10 = 25, one coin of change
    exp_ev(K_CREDIT, 5);
    exp_ev(K_CREDIT, 15);
    exp_ev(K_CREDIT, 25); exp_ev(K_BUSY, 1);
    exp_ev(K_DISP, 1);
    exp_ev(K_CREDIT, 5); exp_ev(K_DISP, 0); exp_ev(K_REQ, 1);
    exp_ev(K_CREDIT, 0); exp_ev(K_REQ, 0); exp_ev(K_BUSY, 0);
    pulse(0); pulse(1); pulse(1);
    wait_sig(0, 1'b1, 20, "t2_dispense_rise");
    tick();
    vend_done = 1'b1;
    tick();
    vend_done = 1'b0;
    wait_drain(40, "t2_drain");

    // cancel in IDLE ignored; held coin counts once; double coin rejected; refund of 15
    exp_ev(K_CREDIT, 5);
    exp_ev(K_CREDIT, 15);
    exp_ev(K_REJ, 1);
    exp_ev(K_REQ, 1); exp_ev(K_BUSY, 1);
    exp_ev(K_CREDIT, 10);
    exp_ev(K_CREDIT, 5);
    exp_ev(K_CREDIT, 0); exp_ev(K_REQ, 0); exp_ev(K_BUSY, 0);
    pulse(2);
    coin5 = 1'b1;
    repeat (30) tick();
    coin5 = 1'b0;
    tick();
    pulse(1);
    coin5 = 1'b1;
    coin10 = 1'b1;
    tick();
    coin5 = 1'b0;
    coin10 = 1'b0;
    tick();
    vend_done = 1'b1;
    tick();
    vend_done = 1'b0;
    tick();
    pulse(2);
    wait_drain(40, "t3_drain");

    // coin and cancel together in COLLECT: cancel wins, coin rejected
    exp_ev(K_CREDIT, 5);
    exp_ev(K_REJ, 1); exp_ev(K_REQ, 1); exp_ev(K_BUSY, 1);
    exp_ev(K_CREDIT, 0); exp_ev(K_REQ, 0); exp_ev(K_BUSY, 0);
    pulse(0);
    coin10 = 1'b1;
    cancel = 1'b1;
    tick();
    coin10 = 1'b0;
    cancel = 1'b0;
    tick();
    wait_drain(40, "t4_drain");

    // coin during VEND rejected, then reset in the middle of CHANGE
    hop_en = 1'b0;
    exp_ev(K_CREDIT, 5);
    exp_ev(K_CREDIT, 15);
    exp_ev(K_CREDIT, 25); exp_ev(K_BUSY, 1);
    exp_ev(K_DISP, 1);
    exp_ev(K_REJ, 1);
    exp_ev(K_CREDIT, 5); exp_ev(K_DISP, 0); exp_ev(K_REQ, 1);
    pulse(0); pulse(1); pulse(1);
    wait_sig(0, 1'b1, 20, "t5_dispense_rise");
    pulse(1);
    vend_done = 1'b1;
    tick();
    vend_done = 1'b0;
    @(negedge clk);
    #1;
    chk("t5_credit_in_change", int'(credit), 5);
    chk("t5_req_in_change", int'(change_req), 1);
    rst = 1'b0;
    #1;
    chk("t5_rst_credit", int'(credit), 0);
    chk("t5_rst_change_req", int'(change_req), 0);
    chk("t5_rst_busy", int'(busy), 0);
    chk("t5_rst_dispense", int'(dispense), 0);
    wait_drain(2, "t5_drain");
    rst = 1'b1;
    hop_en = 1'b1;
    tick();
    chk("t5_post_rst_credit", int'(credit), 0);

    // 10 credit left alone: auto-refund when timeout is built, else refund by cancel
    exp_ev(K_CREDIT, 10);
    exp_ev(K_REQ, 1); exp_ev(K_BUSY, 1);
    exp_ev(K_CREDIT, 5);
    exp_ev(K_CREDIT, 0); exp_ev(K_REQ, 0); exp_ev(K_BUSY, 0);
    pulse(1);
`ifdef VEND_TIMEOUT_EN
    wait_sig(1, 1'b1, TMO + 20, "t6_timeout_refund");
`else
    repeat (300) tick();
    chk("t6_no_timeout_busy", int'(busy), 0);
    chk("t6_no_timeout_credit", int'(credit), 10);
    pulse(2);
`endif
    wait_drain(40, "t6_drain");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, err_count);
    $finish;
  end

endmodule
